// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   - state_e     : scheduler FSM states
//   - NB_STATE    : width of the state encoding
//   - NB_DATA_DEF : default payload bits per UART frame
//   - N_BYTES_DEF : default bytes per message
package uart_tx_scheduler_pkg;

    localparam int NB_STATE    = 2;
    localparam int NB_DATA_DEF = 8;
    localparam int N_BYTES_DEF = 4;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one past the previous winner and wraps, so the requester
// that won last time has the lowest priority on the next decision.
// Ports:
//   req_i        in  N_REQ   request vector
//   last_grant_i in  NB_REQ  index of the previous winner
//   grant_o      out NB_REQ  index of the winner (valid when any_req_o)
//   any_req_o    out 1       at least one request is active
module rr_arbiter #(
    parameter int N_REQ  = 2,
    parameter int NB_REQ = 1
) (
    input  logic [N_REQ-1:0]  req_i,
    input  logic [NB_REQ-1:0] last_grant_i,
    output logic [NB_REQ-1:0] grant_o,
    output logic              any_req_o
);

    int idx;

    // Walk from the farthest candidate to the nearest one so that the nearest
    // active requester (after last_grant) is the one left in grant_o.
    always_comb begin
        grant_o   = '0;
        any_req_o = |req_i;
        idx       = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(last_grant_i) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_i[idx]) begin
                grant_o = NB_REQ'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among N_REQ
// requesters. A granted message of N_BYTES bytes is sent LSB byte first, one
// frame per byte; each byte holds o_tx_start for START_HOLD cycles and then
// waits for a rising edge on i_tx_done, aborting after TIMEOUT cycles.
// Ports:
//   i_clock      in  1                       system clock
//   i_reset_n    in  1                       asynchronous reset, active low
//   i_req_valid  in  N_REQ                   requester k has a message
//   i_req_data   in  N_REQ*N_BYTES*NB_DATA   message k in slice k, byte 0 in LSBs
//   o_req_ready  out N_REQ                   one-cycle pulse: message k captured
//   o_tx_start   out 1                       uart_tx start
//   o_tx_data    out NB_DATA                 uart_tx data, valid while o_tx_start
//   i_tx_done    in  1                       uart_tx done flag
//   o_busy       out 1                       scheduler not idle
//   o_msg_done   out 1                       one-cycle pulse: message complete
//   o_msg_src    out NB_REQ                  current/last granted requester
//   o_error      out 1                       one-cycle pulse: done timeout abort
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEF,
    parameter int N_BYTES     = N_BYTES_DEF,
    parameter int NB_BYTE_CNT = 2,
    parameter int N_REQ       = 2,
    parameter int NB_REQ      = 1,
    parameter int START_HOLD  = 16,
    parameter int TIMEOUT     = 4096,
    parameter int NB_TIMEOUT  = 12
) (
    input  logic                             i_clock,
    input  logic                             i_reset_n,
    input  logic [N_REQ-1:0]                 i_req_valid,
    input  logic [N_REQ*N_BYTES*NB_DATA-1:0] i_req_data,
    output logic [N_REQ-1:0]                 o_req_ready,
    output logic                             o_tx_start,
    output logic [NB_DATA-1:0]               o_tx_data,
    input  logic                             i_tx_done,
    output logic                             o_busy,
    output logic                             o_msg_done,
    output logic [NB_REQ-1:0]                o_msg_src,
    output logic                             o_error
);

    localparam int MSG_W   = N_BYTES * NB_DATA;
    localparam int NB_HOLD = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

    localparam logic [NB_HOLD-1:0]     HOLD_LAST = NB_HOLD'(START_HOLD - 1);
    localparam logic [NB_TIMEOUT-1:0]  TO_LAST   = NB_TIMEOUT'(TIMEOUT - 1);
    localparam logic [NB_BYTE_CNT-1:0] BYTE_LAST = NB_BYTE_CNT'(N_BYTES - 1);

    state_e                  state_q,      state_d;
    logic [MSG_W-1:0]        shift_q,      shift_d;
    logic [NB_BYTE_CNT-1:0]  byte_cnt_q,   byte_cnt_d;
    logic [NB_HOLD-1:0]      hold_cnt_q,   hold_cnt_d;
    logic [NB_TIMEOUT-1:0]   timeout_q,    timeout_d;
    logic [NB_REQ-1:0]       last_grant_q, last_grant_d;
    logic [NB_REQ-1:0]       src_q,        src_d;
    logic [N_REQ-1:0]        ready_q,      ready_d;
    logic                    error_q,      error_d;
    logic                    done_q;

    logic [NB_REQ-1:0]       grant;
    logic                    any_req;
    logic                    done_rise;
    logic [MSG_W-1:0]        msg_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign msg_slice[gi] = i_req_data[gi*MSG_W +: MSG_W];
    end

    rr_arbiter #(
        .N_REQ  (N_REQ),
        .NB_REQ (NB_REQ)
    ) u_arb (
        .req_i        (i_req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .any_req_o    (any_req)
    );

    // Only a low-to-high transition counts, so a done level left over from
    // the previous frame cannot advance the byte.
    assign done_rise = i_tx_done & ~done_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        timeout_d    = timeout_q;
        last_grant_d = last_grant_q;
        src_d        = src_q;
        ready_d      = '0;
        error_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    shift_d        = msg_slice[grant];
                    last_grant_d   = grant;
                    src_d          = grant;
                    byte_cnt_d     = '0;
                    hold_cnt_d     = '0;
                    ready_d[grant] = 1'b1;
                    state_d        = ST_START;
                end
            end
            ST_START: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    timeout_d = '0;
                    state_d   = ST_WAIT;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // A rise on the final cycle wins over the timeout.
                if (done_rise) begin
                    if (byte_cnt_q == BYTE_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        shift_d    = shift_q >> NB_DATA;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        hold_cnt_d = '0;
                        state_d    = ST_START;
                    end
                end else if (timeout_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            timeout_q    <= '0;
            last_grant_q <= NB_REQ'(N_REQ - 1);
            src_q        <= '0;
            ready_q      <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            timeout_q    <= timeout_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            done_q       <= i_tx_done;
        end
    end

    // Decoded straight from the state register so an asynchronous reset
    // clears them immediately; data is forced to zero outside START.
    assign o_tx_start  = (state_q == ST_START);
    assign o_tx_data   = o_tx_start ? shift_q[NB_DATA-1:0] : '0;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_msg_done  = (state_q == ST_DONE);
    assign o_msg_src   = src_q;
    assign o_req_ready = ready_q;
    assign o_error     = error_q;

endmodule
